// File: rtl/mult_sched.sv
// mult_sched: arbitrates two issue lanes onto one 32x32 shift-add multiplier,
// owns HI/LO and raises per-lane stalls for multiplier and HI/LO hazards.
module mult_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        start0,
    input  logic        start1,
    input  logic        sgn0,
    input  logic        sgn1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        rdhl0,
    input  logic        rdhl1,
    output logic        grant0,
    output logic        grant1,
    output logic        stall0,
    output logic        stall1,
    output logic        busy,
    output logic        prodv,
    output logic        owner,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [31:0] mcand, mplier, xa, xb;
    logic [63:0] acc, nacc;
    logic [32:0] sum;
    logic [4:0]  cnt;
    logic        neg, run, xs;
    assign run    = state == RUN;
    assign grant0 = start0 & ~run;
    assign grant1 = start1 & ~start0 & ~run;
    // lane 0 is older, so a lane-1 accept never hides HI/LO from a lane-0 read
    assign stall0 = (start0 & ~grant0) | (rdhl0 & busy);
    assign stall1 = (start1 & ~grant1) | (rdhl1 & (busy | grant0));
    assign xs     = grant1 ? sgn1 : sgn0;
    assign xa     = grant1 ? a1 : a0;
    assign xb     = grant1 ? b1 : b0;
    assign sum    = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    assign nacc   = {sum, acc[31:1]};
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            prodv  <= 1'b0;
            owner  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else if (grant0 | grant1) begin
            state  <= RUN;
            busy   <= 1'b1;
            prodv  <= 1'b0;
            owner  <= grant1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= (xs & xa[31]) ? -xa : xa;
            mplier <= (xs & xb[31]) ? -xb : xb;
            neg    <= xs & (xa[31] ^ xb[31]);
        end else if (run) begin
            acc    <= nacc;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                {hi, lo} <= neg ? -nacc : nacc;
                prodv    <= 1'b1;
                busy     <= 1'b0;
                state    <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed and random checks of mult_sched against a
// reference 64-bit product, using a grant-ordered scoreboard.
module tb_mult_sched;
    logic        clk = 1'b0, reset = 1'b1;
    logic        start0 = 0, start1 = 0, sgn0 = 0, sgn1 = 0, rdhl0 = 0, rdhl1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        grant0, grant1, stall0, stall1, busy, prodv, owner;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0;
    logic [64:0] sb[$];
    logic        pq = 1'b0;

    mult_sched dut (
        .clk(clk), .reset(reset), .start0(start0), .start1(start1),
        .sgn0(sgn0), .sgn1(sgn1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .rdhl0(rdhl0), .rdhl1(rdhl1), .grant0(grant0), .grant1(grant1),
        .stall0(stall0), .stall1(stall1), .busy(busy), .prodv(prodv),
        .owner(owner), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'd0, a};
        y = s ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    function automatic logic [31:0] rop();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? 32'h0 : k == 1 ? 32'h1 : k == 2 ? 32'hFFFFFFFF :
               k == 3 ? 32'h80000000 : k == 4 ? 32'h7FFFFFFF : $urandom;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (grant0 | grant1) begin
                check("grant_while_busy", {63'd0, busy}, 64'd0);
                sb.push_back(grant0 ? {1'b0, ref_prod(sgn0, a0, b0)} : {1'b1, ref_prod(sgn1, a1, b1)});
            end
            if (prodv && !pq) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    logic [64:0] e;
                    e = sb.pop_front();
                    check("sb_prod", {hi, lo}, e[63:0]);
                    check("sb_owner", {63'd0, owner}, {63'd0, e[64]});
                end
            end
        end
        pq = prodv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input bit chk_lat);
        int n;
        n = 0;
        #1;
        while (!prodv && n < 60) begin
            tick();
            n++;
        end
        if (chk_lat) check(tag, n, 32);
        else check(tag, {63'd0, prodv}, 64'd1);
    endtask

    task automatic issue(input logic s0, input logic s1);
        int n;
        logic g0, g1;
        start0 = s0;
        start1 = s1;
        n = 0;
        while ((start0 | start1) && n < 200) begin
            #1;
            g0 = grant0;
            g1 = grant1;
            tick();
            if (g0) start0 = 1'b0;
            if (g1) start1 = 1'b0;
            n++;
        end
        check("issue_timeout", {63'd0, start0 | start1}, 64'd0);
        wait_done("op_timeout", 1'b0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 0);
        check("rst_prodv", {63'd0, prodv}, 0);
        check("rst_owner", {63'd0, owner}, 0);
        check("rst_hilo", {hi, lo}, 0);
        // unsigned max * max
        start0 = 1; sgn0 = 0; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
        #1;
        check("u_grant0", {63'd0, grant0}, 1);
        tick();
        start0 = 0;
        check("u_busy", {63'd0, busy}, 1);
        wait_done("u_latency", 1'b1);
        check("u_hi", hi, 32'hFFFFFFFE);
        check("u_lo", lo, 32'h00000001);
        check("u_busy_end", {63'd0, busy}, 0);
        check("u_owner", {63'd0, owner}, 0);
        // signed lane 1
        sgn1 = 1; a1 = -32'sd3; b1 = 32'd7;
        issue(0, 1);
        check("s_hi", hi, 32'hFFFFFFFF);
        check("s_lo", lo, 32'hFFFFFFEB);
        check("s_owner", {63'd0, owner}, 1);
        a1 = 32'h80000000; b1 = 32'h80000000;
        issue(0, 1);
        check("s_min_hilo", {hi, lo}, 64'h4000000000000000);
        // contention from IDLE
        reset = 1; tick(); reset = 0;
        sgn0 = 0; a0 = 32'd12345; b0 = 32'd678;
        sgn1 = 1; a1 = 32'hFFFFFFF0; b1 = 32'd9;
        start0 = 1; start1 = 1;
        #1;
        check("c_grant0", {63'd0, grant0}, 1);
        check("c_grant1", {63'd0, grant1}, 0);
        n = 0;
        while (stall1 && n < 100) begin
            n++;
            tick();
            start0 = 0;
            #1;
        end
        check("c_stall1_cycles", n, 33);
        check("c_grant1_done", {63'd0, grant1}, 1);
        tick();
        start1 = 0;
        wait_done("c_lat1", 1'b1);
        check("c_owner1", {63'd0, owner}, 1);
        // HI/LO hazards
        start0 = 1; rdhl1 = 1; a0 = 32'd5; b0 = 32'd6;
        #1;
        check("h_grant0", {63'd0, grant0}, 1);
        check("h_stall1_rdhl", {63'd0, stall1}, 1);
        tick();
        start0 = 0; rdhl1 = 0; rdhl0 = 1;
        #1;
        n = 0;
        while (!prodv && n < 60) begin
            if (stall0) n++;
            tick();
        end
        check("h_stall0_cycles", n, 32);
        check("h_stall0_end", {63'd0, stall0}, 0);
        start1 = 1; a1 = 32'd3; b1 = 32'd3;
        #1;
        check("h_grant1", {63'd0, grant1}, 1);
        check("h_stall0_g1", {63'd0, stall0}, 0);
        tick();
        start1 = 0; rdhl0 = 0;
        wait_done("h_done", 1'b0);
        // reset mid-operation
        start0 = 1; a0 = 32'hDEAD; b0 = 32'hBEEF;
        tick();
        start0 = 0;
        repeat (15) tick();
        reset = 1;
        tick();
        #1;
        check("r_busy", {63'd0, busy}, 0);
        check("r_prodv", {63'd0, prodv}, 0);
        check("r_hilo", {hi, lo}, 0);
        reset = 0; start0 = 1;
        #1;
        check("r_regrant", {63'd0, grant0}, 1);
        tick();
        start0 = 0;
        wait_done("r_lat", 1'b1);
        // random regression
        for (int i = 0; i < 1000; i++) begin
            int k;
            k = $urandom_range(0, 2);
            sgn0 = 1'($urandom); sgn1 = 1'($urandom);
            a0 = rop(); b0 = rop(); a1 = rop(); b1 = rop();
            issue(k != 1, k != 0);
        end
        tick();
        check("sb_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
